prog_loader: RTL and testbench

//   Byte-stream boot loader upstream of the single-cycle MIPS core. Receives a framed

---
 rtl/prog_loader_pkg.sv | 12 +
 rtl/prog_loader_if.sv | 21 ++
 rtl/prog_loader_byte_packer.sv | 23 ++
 rtl/prog_loader.sv | 88 ++++++++
 tb/tb_prog_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: loader FSM state encoding and frame header length
package prog_loader_pkg;
  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;
  localparam int HDR_LEN = 2;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream in (in_data/in_valid/in_ready/reload), imem write port and core status out
interface prog_loader_if #(parameter int ADDR_W = 8);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic reload;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic core_reset;
  logic done;
  logic error;
  modport master (
    output in_data, in_valid, reload,
    input in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
  );
  modport slave (
    input in_data, in_valid, reload,
    output in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// prog_loader_byte_packer: clk/clr/shift/din in, word (incl. current din) and word_valid on 4th byte out
module prog_loader_byte_packer (
  input  logic        clk,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [23:0] sr;
  logic [1:0]  cnt;
  assign word = {sr, din};
  assign word_valid = shift & (cnt == 2'd3);
  always_ff @(posedge clk) begin
    if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[15:0], din};
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: clk/reset plus bus (slave: byte stream in, imem write port, core_reset/done/error out); framed boot loader
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic reset,
  prog_loader_if.slave bus
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
  state_t      state;
  logic [15:0] len;
  logic [15:0] wcnt;
  logic [7:0]  csum;
  logic [31:0] word;
  logic        word_valid;
  logic        xfer;
  logic        clr;
  logic [16:0] n_req;
  assign xfer  = bus.in_valid & bus.in_ready;
  assign clr   = reset | bus.reload;
  assign n_req = {1'b0, len[15:8], bus.in_data};
  prog_loader_byte_packer packer (
    .clk(clk),
    .clr(clr),
    .shift(xfer && state == S_DATA),
    .din(bus.in_data),
    .word(word),
    .word_valid(word_valid)
  );
  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= S_LEN_HI;
      len            <= '0;
      wcnt           <= '0;
      csum           <= '0;
      bus.in_ready   <= 1'b1;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.core_reset <= 1'b1;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      if (xfer) begin
        case (state)
          S_LEN_HI: begin
            len[15:8] <= bus.in_data;
            state     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len[7:0] <= bus.in_data;
            if (n_req == '0) state <= S_CSUM;
            else if (n_req > CAP) begin
              state        <= S_ERR;
              bus.in_ready <= 1'b0;
              bus.error    <= 1'b1;
            end else state <= S_DATA;
          end
          S_DATA: begin
            csum <= csum ^ bus.in_data;
            if (word_valid) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= word;
              bus.imem_addr  <= wcnt[ADDR_W-1:0];
              wcnt           <= wcnt + 16'd1;
              if (wcnt == len - 16'd1) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum) begin
              state          <= S_DONE;
              bus.done       <= 1'b1;
              bus.core_reset <= 1'b0;
            end else begin
              state     <= S_ERR;
              bus.error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table vectors, corner sequences and random frames against a frame-level reference model
module tb_prog_loader;
  import prog_loader_pkg::*;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  prog_loader_if #(.ADDR_W(AW)) bus ();
  prog_loader #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] frame[$];
  int got_a[$];
  logic [31:0] got_d[$];
  int exp_a[$];
  logic [31:0] exp_d[$];
  bit exp_done;
  bit exp_err;
  typedef struct {
    logic [0:10][7:0] b;
    int nb;
    int gap;
    bit done_e;
    bit err_e;
    int nw_e;
  } vec_t;
  vec_t vt[5];
  always @(negedge clk) begin
    if (bus.imem_we) begin
      got_a.push_back(int'(bus.imem_addr));
      got_d.push_back(bus.imem_wdata);
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic vec_t mkv(input logic [87:0] bits, input int nb, input int gap,
                               input bit d, input bit e, input int nw);
    vec_t v;
    v.b = bits;
    v.nb = nb;
    v.gap = gap;
    v.done_e = d;
    v.err_e = e;
    v.nw_e = nw;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic push_byte(input logic [7:0] b, input int gap);
    int t = 0;
    bus.in_data = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) begin
      chk("ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_frame(input int gap);
    foreach (frame[i]) push_byte(frame[i], gap);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_a.delete();
    got_d.delete();
  endtask
  task automatic pulse_reload();
    bus.in_valid = 1'b0;
    bus.reload = 1'b1;
    @(posedge clk);
    #1;
    bus.reload = 1'b0;
    got_a.delete();
    got_d.delete();
  endtask
  task automatic build_frame(input int n, input bit bad);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    if (n > (1 << AW)) return;
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      frame.push_back(b);
      x ^= b;
    end
    frame.push_back(bad ? x ^ (8'h01 << $urandom_range(0, 7)) : x);
  endtask
  // Reference: parse the frame as a whole, list expected writes and final status.
  task automatic model_frame();
    int n;
    logic [7:0] x = 8'h00;
    exp_a.delete();
    exp_d.delete();
    exp_done = 1'b0;
    exp_err = 1'b0;
    n = int'({frame[0], frame[1]});
    if (n > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_a.push_back(w);
      exp_d.push_back({frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
    end
    for (int k = 2; k < 2 + 4 * n; k++) x ^= frame[k];
    if (frame[2+4*n] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask
  task automatic check_result(input string tag);
    chk({tag, "_nwr"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk({tag, "_addr"}, got_a[i], exp_a[i]);
      chk({tag, "_data"}, got_d[i], exp_d[i]);
    end
    chk({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    chk({tag, "_error"}, 32'(bus.error), 32'(exp_err));
    chk({tag, "_core_reset"}, 32'(bus.core_reset), 32'(!exp_done));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(!(exp_done || exp_err)));
    chk({tag, "_we_idle"}, 32'(bus.imem_we), 32'd0);
  endtask
  initial begin
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    vt[0] = mkv({8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E}, 11, 0, 1, 0, 2);
    vt[1] = mkv({8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0F}, 11, 0, 0, 1, 2);
    vt[2] = mkv({8'h00, 8'h00, 8'h00, 64'h0}, 3, 0, 1, 0, 0);
    vt[3] = mkv({8'h01, 8'h01, 72'h0}, 2, 0, 0, 1, 0);
    vt[4] = mkv({8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E}, 11, 2, 1, 0, 2);
    for (int i = 0; i < 5; i++) begin
      pulse_reset();
      frame.delete();
      for (int j = 0; j < vt[i].nb; j++) frame.push_back(vt[i].b[j]);
      model_frame();
      send_frame(vt[i].gap);
      chk($sformatf("vec%0d_nw", i), got_a.size(), vt[i].nw_e);
      chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vt[i].done_e));
      chk($sformatf("vec%0d_error", i), 32'(bus.error), 32'(vt[i].err_e));
      if (vt[i].nw_e == 2 && got_d.size() == 2) begin
        chk($sformatf("vec%0d_w0", i), got_d[0], 32'h20080005);
        chk($sformatf("vec%0d_w1", i), got_d[1], 32'h2009000A);
      end
      check_result($sformatf("vec%0d", i));
    end
    pulse_reset();
    frame.delete();
    for (int j = 0; j < 7; j++) frame.push_back(vt[0].b[j]);
    foreach (frame[i]) push_byte(frame[i], 0);
    @(posedge clk);
    #1;
    chk("t6_partial_writes", got_a.size(), 1);
    pulse_reset();
    frame.delete();
    for (int j = 0; j < 11; j++) frame.push_back(vt[0].b[j]);
    model_frame();
    send_frame(0);
    check_result("t6");
    pulse_reload();
    chk("t7_core_reset", 32'(bus.core_reset), 32'd1);
    chk("t7_done", 32'(bus.done), 32'd0);
    chk("t7_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t7_error", 32'(bus.error), 32'd0);
    build_frame(3, 1'b0);
    model_frame();
    send_frame(1);
    check_result("t7");
    pulse_reload();
    push_byte(8'h00, 0);
    push_byte(8'h01, 0);
    bus.in_data = 8'h55;
    bus.in_valid = 1'b1;
    bus.reload = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.reload = 1'b0;
    got_a.delete();
    got_d.delete();
    build_frame(1, 1'b0);
    model_frame();
    send_frame(0);
    check_result("reload_drop");
    pulse_reload();
    build_frame(1 << AW, 1'b0);
    model_frame();
    send_frame(0);
    check_result("full_cap");
    for (int r = 0; r < 25; r++) begin
      int n;
      pulse_reload();
      n = ($urandom_range(0, 5) == 0) ? 257 + $urandom_range(0, 500) : $urandom_range(0, 6);
      build_frame(n, $urandom_range(0, 3) == 0);
      model_frame();
      send_frame($urandom_range(0, 2));
      check_result($sformatf("rnd%0d", r));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
